regfile_bypass: RTL and testbench
=================================

// Module: regfile_bypass
// PURPOSE
//   Responder end of the register-file port protocol driven by the HW4 test bench:
//   2 async read ports, 1 clocked write port, register 0 hardwired to zero.
//   After reset a clear FSM zeroes every register, one per cycle, and then raises Ready.
//   Optional same-cycle write->read bypass. Sits under the CPU datapath and the test harness.
// PARAMETERS
//   WIDTH   32  data width of each register
//   ADDR_W  5   address width; depth = 2**ADDR_W
//   BYPASS  1   1: a read of the register being written returns WriteData in the same cycle
// PORTS
//   Clk            in   1       clock; all state updates on the posedge
//   Reset_n        in   1       synchronous, active-low reset
//   ReadRegister1  in   ADDR_W  read port 1 address
//   ReadRegister2  in   ADDR_W  read port 2 address
//   ReadData1      out  WIDTH   read port 1 data (combinational)
//   ReadData2      out  WIDTH   read port 2 data (combinational)
//   WriteRegister  in   ADDR_W  write address
//   WriteData      in   WIDTH   write data
//   RegWrite       in   1       write enable, sampled at posedge Clk
//   Ready          out  1       high once the clear sequence is complete; writes accepted only then
// BEHAVIOUR
//   Reset: a posedge with Reset_n=0 sets state<=CLEAR, ClrPtr<=1, Ready<=0.
//     Register contents are not touched directly; CLEAR overwrites them.
//   FSM CLEAR: each posedge writes 0 to reg[ClrPtr], then ClrPtr++.
//     After the posedge that writes reg[2**ADDR_W-1]: state<=RUN, Ready<=1.
//     Result: Ready rises 31 posedges after the reset posedge (ADDR_W=5).
//   FSM RUN: terminal state. Only Reset_n=0 leaves it, back to CLEAR.
//   Write: at posedge, when Ready && RegWrite && WriteRegister!=0, reg[WriteRegister]<=WriteData.
//     - RegWrite=0: no register changes.
//     - WriteRegister=0: write dropped.
//     - Exactly one register is written per accepted write (one-hot decode).
//     - Writes while Ready=0 are dropped, not queued.
//   Read: ReadDataN = 0 if ReadRegisterN==0 or Ready==0; otherwise reg[ReadRegisterN].
//     Both ports are independent; the same address on both ports returns identical data.
//   Bypass (BYPASS=1): when Ready && RegWrite && WriteRegister==ReadRegisterN!=0,
//     ReadDataN=WriteData combinationally, before the edge.
//     With BYPASS=0 the new value is visible only after the posedge.
//   Reset mid-operation: Reset_n=0 during CLEAR or RUN restarts CLEAR from ClrPtr=1.
//     Ready drops to 0 at that posedge.
//   Reset wins over RegWrite in the same cycle: that write is dropped.
//   Latency: write-to-read = 1 posedge (0 with bypass). Read = combinational, no clock.
// STRUCTURE
//   Shared include regfile_defs.vh: `REG_WIDTH 32, `REG_ADDR_W 5,
//     and the FSM state encodings ST_CLEAR=1'b0, ST_RUN=1'b1.
//   Sub-module decoder_1to32: ADDR_W -> 2**ADDR_W one-hot, with enable (RegWrite & Ready).
//   Storage: register array of WIDTH-bit flops with per-register enable.
//   Read muxes and the bypass compare are inline; the CLEAR counter and FSM are inline.
// TESTING  (drive as the HW4 bench does: set inputs, pulse Clk, check after the falling edge)
//   1 Reset_n=0 for 1 posedge, then 1. Count posedges until Ready=1 -> exactly 31.
//     Every ReadDataN=0 throughout; every register reads 0 after Ready.
//   2 Ready=1: write 42 to reg 2, then 15 to reg 2.
//     -> ReadData1=ReadData2=42 after the first edge, 15 after the second.
//   3 RegWrite=0, WriteData=20, WriteRegister=2 -> reg 2 still reads 15.
//     Write 25 to reg 2, read reg 3 -> reg 3 reads 0, not 25.
//   4 Write 30 to reg 0 -> both ports read 0.
//     Write 35 to reg 17, read ports 1 and 2 at reg 17 -> both read 35.
//     Read reg 3 on port 2 -> 0 (catches a stuck port).
//   5 BYPASS=1: RegWrite=1, WriteRegister=5, WriteData=99, ReadRegister1=5, before the edge
//     -> ReadData1=99. BYPASS=0 -> old value 0 before the edge, 99 after it.
//   6 Assert Reset_n=0 at posedge 10 of CLEAR and at a posedge during RUN
//     -> Ready=0 from that edge, reads return 0, Ready returns 31 edges later.
//     A RegWrite during CLEAR is not retained.

Source files
------------

// File: rtl/regfile_bypass_pkg.sv
// ---------------------------------------------------------------------------
// regfile_bypass_pkg : shared widths and clear/run state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package regfile_bypass_pkg;

  localparam int REG_WIDTH  = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/regfile_bypass_decoder.sv
// ---------------------------------------------------------------------------
// regfile_bypass_decoder : address to one-hot write-select decoder with enable
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_bypass_decoder
  import regfile_bypass_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    addr,
  output logic [2**ADDR_W-1:0] onehot
);

  localparam int DEPTH = 2**ADDR_W;

  always_comb begin
    onehot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      onehot[i] = en && (addr == ADDR_W'(i));
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_bypass.sv
// ---------------------------------------------------------------------------
// regfile_bypass : 2R/1W register file, r0 = 0, post-reset clear sweep, bypass
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_bypass
  import regfile_bypass_pkg::*;
#(
  parameter int WIDTH  = REG_WIDTH,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              RegWrite,
  output logic              Ready
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

  state_t                         state;
  logic [ADDR_W-1:0]              clr_ptr;
  logic                           clearing;
  logic [DEPTH-1:0]               wr_sel;
  logic [DEPTH-1:0][WIDTH-1:0]    regs;

  // Clear sweep: one register per edge from 1 up to the top, then run forever.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state   <= ST_CLEAR;
      clr_ptr <= ADDR_W'(1);
      Ready   <= 1'b0;
    end else if (state == ST_CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (clr_ptr == LAST_PTR) begin
        state <= ST_RUN;
        Ready <= 1'b1;
      end
    end
  end

  assign clearing = (state == ST_CLEAR);

  // The same select lines drive both the flop enables and the bypass compare.
  regfile_bypass_decoder #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .en     (RegWrite && Ready),
    .addr   (WriteRegister),
    .onehot (wr_sel)
  );

  assign regs[0] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    logic [WIDTH-1:0] q;
    logic             clr_hit;

    assign clr_hit = clearing && (clr_ptr == ADDR_W'(i));

    // Storage has no reset of its own; a low Reset_n only blocks updates.
    always_ff @(posedge Clk) begin
      if (Reset_n) begin
        if (clr_hit) begin
          q <= '0;
        end else if (wr_sel[i]) begin
          q <= WriteData;
        end
      end
    end

    assign regs[i] = q;
  end

  always_comb begin
    ReadData1 = '0;
    if (Ready && (ReadRegister1 != '0)) begin
      ReadData1 = regs[ReadRegister1];
      if ((BYPASS != 0) && wr_sel[ReadRegister1]) begin
        ReadData1 = WriteData;
      end
    end
  end

  always_comb begin
    ReadData2 = '0;
    if (Ready && (ReadRegister2 != '0)) begin
      ReadData2 = regs[ReadRegister2];
      if ((BYPASS != 0) && wr_sel[ReadRegister2]) begin
        ReadData2 = WriteData;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_bypass.sv
// ---------------------------------------------------------------------------
// tb_regfile_bypass : directed bench for regfile_bypass (bypass and no-bypass)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile_bypass;

  logic        Clk;
  logic        Reset_n;
  logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        Ready, nb_ready;

  int tests = 0;
  int fails = 0;

  regfile_bypass #(.WIDTH(32), .ADDR_W(5), .BYPASS(1)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (rd1),
    .ReadData2     (rd2),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite),
    .Ready         (Ready)
  );

  regfile_bypass #(.WIDTH(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (nb_rd1),
    .ReadData2     (nb_rd2),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite),
    .Ready         (nb_ready)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    Clk = 1'b1;
    #5;
    Clk = 1'b0;
    #5;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2);
    RegWrite      = we;
    WriteRegister = wr;
    WriteData     = wd;
    ReadRegister1 = r1;
    ReadRegister2 = r2;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!Ready && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    Clk = 1'b0;
    Reset_n = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 5'd1, 5'd2);

    vecs[0]  = '{1'b1, 5'd2,  32'd42,        5'd2,  5'd2,  32'd42,        32'd42};
    vecs[1]  = '{1'b1, 5'd2,  32'd15,        5'd2,  5'd2,  32'd15,        32'd15};
    vecs[2]  = '{1'b0, 5'd2,  32'd20,        5'd2,  5'd2,  32'd15,        32'd15};
    vecs[3]  = '{1'b1, 5'd2,  32'd25,        5'd3,  5'd2,  32'd0,         32'd25};
    vecs[4]  = '{1'b1, 5'd0,  32'd30,        5'd0,  5'd0,  32'd0,         32'd0};
    vecs[5]  = '{1'b0, 5'd0,  32'd0,         5'd1,  5'd2,  32'd0,         32'd25};
    vecs[6]  = '{1'b1, 5'd17, 32'd35,        5'd17, 5'd17, 32'd35,        32'd35};
    vecs[7]  = '{1'b0, 5'd0,  32'd0,         5'd17, 5'd3,  32'd35,        32'd0};
    vecs[8]  = '{1'b1, 5'd31, 32'hDEADBEEF,  5'd31, 5'd30, 32'hDEADBEEF,  32'd0};
    vecs[9]  = '{1'b1, 5'd1,  32'hFFFFFFFF,  5'd1,  5'd31, 32'hFFFFFFFF,  32'hDEADBEEF};
    vecs[10] = '{1'b0, 5'd0,  32'd0,         5'd16, 5'd18, 32'd0,         32'd0};

    // Reset, then a clear sweep with writes to reg 7 attempted late in CLEAR.
    #2;
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    check("ready_after_reset", {31'd0, Ready}, 32'd0);
    n = 0;
    while (!Ready && n < 40) begin
      check($sformatf("clear_rd1_edge%0d", n), rd1, 32'd0);
      check($sformatf("clear_rd2_edge%0d", n), rd2, 32'd0);
      if (n >= 20) set_in(1'b1, 5'd7, 32'd77, 5'd7, 5'd1);
      tick();
      n++;
    end
    check("clear_edges", n, 32'd31);
    set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    #1;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      #1;
      check($sformatf("zero_p1_r%0d", i), rd1, 32'd0);
      check($sformatf("zero_p2_r%0d", 31 - i), rd2, 32'd0);
    end

    // Table of post-edge checks on both variants.
    for (int v = 0; v < 11; v++) begin
      set_in(vecs[v].we, vecs[v].wr, vecs[v].wd, vecs[v].r1, vecs[v].r2);
      tick();
      check($sformatf("vec%0d_rd1", v), rd1, vecs[v].e1);
      check($sformatf("vec%0d_rd2", v), rd2, vecs[v].e2);
      check($sformatf("vec%0d_nb_rd1", v), nb_rd1, vecs[v].e1);
      check($sformatf("vec%0d_nb_rd2", v), nb_rd2, vecs[v].e2);
      check($sformatf("vec%0d_ready", v), {31'd0, Ready}, 32'd1);
    end

    // Same-cycle bypass before the edge.
    set_in(1'b1, 5'd5, 32'd99, 5'd5, 5'd5);
    #1;
    check("byp_rd1_pre", rd1, 32'd99);
    check("byp_rd2_pre", rd2, 32'd99);
    check("nobyp_rd1_pre", nb_rd1, 32'd0);
    tick();
    check("nobyp_rd1_post", nb_rd1, 32'd99);
    check("byp_rd1_post", rd1, 32'd99);
    set_in(1'b1, 5'd0, 32'd123, 5'd0, 5'd17);
    #1;
    check("byp_r0_pre", rd1, 32'd0);
    check("byp_other_port", rd2, 32'd35);
    set_in(1'b1, 5'd6, 32'd66, 5'd17, 5'd5);
    #1;
    check("byp_nomatch_p1", rd1, 32'd35);
    check("byp_nomatch_p2", rd2, 32'd99);
    tick();
    set_in(1'b0, 5'd0, 32'd0, 5'd6, 5'd5);
    #1;
    check("post_byp_r6", rd1, 32'd66);

    // Reset during RUN with a write pending: Ready drops at that edge.
    Reset_n = 1'b0;
    set_in(1'b1, 5'd9, 32'd55, 5'd17, 5'd5);
    tick();
    Reset_n = 1'b1;
    RegWrite = 1'b0;
    check("run_reset_ready", {31'd0, Ready}, 32'd0);
    check("run_reset_rd1", rd1, 32'd0);
    check("run_reset_rd2", rd2, 32'd0);

    // Reset again at edge 10 of that CLEAR.
    for (int e = 0; e < 9; e++) tick();
    check("mid_clear_ready", {31'd0, Ready}, 32'd0);
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    check("mid_clear_reset_ready", {31'd0, Ready}, 32'd0);
    wait_ready(n);
    check("reclear_edges", n, 32'd31);
    set_in(1'b0, 5'd0, 32'd0, 5'd17, 5'd5);
    #1;
    check("reclear_r17", rd1, 32'd0);
    check("reclear_r5", rd2, 32'd0);
    ReadRegister1 = 5'd9;
    ReadRegister2 = 5'd31;
    #1;
    check("reclear_r9", rd1, 32'd0);
    check("reclear_r31", rd2, 32'd0);
    check("nb_ready_match", {31'd0, nb_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
